jtcontra_gfx_romarb: RTL and testbench

- Arbitrates the single 16-bit graphics ROM SDRAM slot of one 007121 instance between two fetchers: the tilemap engine and the object (sprite) engine.
- Each requester uses the codebase's cs/addr/ok/data handshake.
- Tilemap has fixed priority. A starvation counter guarantees object fetches progress during long tilemap bursts.
- Sits between the gfx engines and the SDRAM controller slot, inside the 007121 gfx wrapper.

---
 rtl/jtcontra_gfx_pkg.sv | 14 +
 rtl/jtcontra_romarb_port.sv | 43 ++++
 rtl/jtcontra_gfx_romarb.sv | 145 ++++++++++++++
 tb/tb_jtcontra_gfx_romarb.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jtcontra_gfx_pkg.sv
// Shared definitions for the 007121 graphics ROM path: default bus widths
// and the ROM-slot arbiter state encoding.
package jtcontra_gfx_pkg;

   localparam int GFX_AW = 18;
   localparam int GFX_DW = 16;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_WAIT_T = 2'd1,
      ST_WAIT_O = 2'd2
   } arb_state_t;

endpackage

// File: rtl/jtcontra_romarb_port.sv
// One requester side of the graphics ROM arbiter: remembers the last word
// delivered, flags hits against it and registers the ok/data outputs.
module jtcontra_romarb_port
   import jtcontra_gfx_pkg::*;
#(
   parameter int AW = GFX_AW,
   parameter int DW = GFX_DW
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          cs,
   input  logic [AW-1:0] addr,
   input  logic          fill,
   input  logic [AW-1:0] fill_addr,
   input  logic [DW-1:0] fill_data,
   output logic          hit,
   output logic          ok,
   output logic [DW-1:0] data
);

   logic [AW-1:0] served_addr;
   logic          served_valid;

   assign hit = cs && served_valid && (addr == served_addr);

   // data only moves on a fill, so a hit keeps presenting the served word
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ok           <= 1'b0;
         data         <= '0;
         served_addr  <= '0;
         served_valid <= 1'b0;
      end else begin
         ok <= hit || fill;
         if (fill) begin
            data         <= fill_data;
            served_addr  <= fill_addr;
            served_valid <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/jtcontra_gfx_romarb.sv
// Shares the single 007121 graphics ROM SDRAM slot between the tilemap
// (fixed priority) and object fetchers, with a starvation escape for objects.
//
// state     | meaning
// ST_IDLE   | no access in flight, choose a missing requester
// ST_WAIT_T | slot granted to tilemap, waiting for rom_ok
// ST_WAIT_O | slot granted to objects, waiting for rom_ok
module jtcontra_gfx_romarb
   import jtcontra_gfx_pkg::*;
#(
   parameter int AW     = GFX_AW,
   parameter int DW     = GFX_DW,
   parameter int STARVE = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          tile_cs,
   input  logic [AW-1:0] tile_addr,
   output logic          tile_ok,
   output logic [DW-1:0] tile_data,
   input  logic          obj_cs,
   input  logic [AW-1:0] obj_addr,
   output logic          obj_ok,
   output logic [DW-1:0] obj_data,
   output logic          rom_cs,
   output logic [AW-1:0] rom_addr,
   input  logic          rom_ok,
   input  logic [DW-1:0] rom_data,
   output logic [2:0]    starve_cnt
);

   arb_state_t    state;
   logic          guard;
   logic          tile_hit;
   logic          obj_hit;
   logic          tile_miss;
   logic          obj_miss;
   logic          in_wait;
   logic          grant_cs;
   logic [AW-1:0] grant_addr;
   logic          done;
   logic          tile_done;
   logic          obj_done;
   logic          starve_full;

   assign tile_miss   = tile_cs && !tile_hit;
   assign obj_miss    = obj_cs && !obj_hit;
   assign starve_full = (starve_cnt == 3'(STARVE));

   assign in_wait    = (state == ST_WAIT_T) || (state == ST_WAIT_O);
   assign grant_cs   = (state == ST_WAIT_O) ? obj_cs : tile_cs;
   assign grant_addr = (state == ST_WAIT_O) ? obj_addr : tile_addr;

   // completion is the last branch of the wait priority chain
   assign done      = in_wait && !guard && grant_cs && (grant_addr == rom_addr) && rom_ok;
   assign tile_done = done && (state == ST_WAIT_T);
   assign obj_done  = done && (state == ST_WAIT_O);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_IDLE;
         guard    <= 1'b0;
         rom_cs   <= 1'b0;
         rom_addr <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (obj_miss && (!tile_miss || starve_full)) begin
                  rom_addr <= obj_addr;
                  rom_cs   <= 1'b1;
                  guard    <= 1'b1;
                  state    <= ST_WAIT_O;
               end else if (tile_miss) begin
                  rom_addr <= tile_addr;
                  rom_cs   <= 1'b1;
                  guard    <= 1'b1;
                  state    <= ST_WAIT_T;
               end
            end
            ST_WAIT_T, ST_WAIT_O: begin
               // the cycle after an issue may still carry the SDRAM's ok for the old address
               if (guard) begin
                  guard <= 1'b0;
               end else if (!grant_cs) begin
                  rom_cs <= 1'b0;
                  state  <= ST_IDLE;
               end else if (grant_addr != rom_addr) begin
                  rom_addr <= grant_addr;
                  guard    <= 1'b1;
               end else if (rom_ok) begin
                  rom_cs <= 1'b0;
                  state  <= ST_IDLE;
               end
            end
            default: begin
               rom_cs <= 1'b0;
               guard  <= 1'b0;
               state  <= ST_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         starve_cnt <= 3'd0;
      end else if (!obj_cs || obj_done) begin
         starve_cnt <= 3'd0;
      end else if (tile_done && !obj_hit && !starve_full) begin
         starve_cnt <= starve_cnt + 3'd1;
      end
   end

   jtcontra_romarb_port #(.AW(AW), .DW(DW)) u_tile (
      .clk       (clk),
      .rst_n     (rst_n),
      .cs        (tile_cs),
      .addr      (tile_addr),
      .fill      (tile_done),
      .fill_addr (rom_addr),
      .fill_data (rom_data),
      .hit       (tile_hit),
      .ok        (tile_ok),
      .data      (tile_data)
   );

   jtcontra_romarb_port #(.AW(AW), .DW(DW)) u_obj (
      .clk       (clk),
      .rst_n     (rst_n),
      .cs        (obj_cs),
      .addr      (obj_addr),
      .fill      (obj_done),
      .fill_addr (rom_addr),
      .fill_data (rom_data),
      .hit       (obj_hit),
      .ok        (obj_ok),
      .data      (obj_data)
   );

   a_cs_tracks_state: assert property (@(posedge clk) disable iff (!rst_n)
      rom_cs == (state != ST_IDLE));
   a_starve_bound: assert property (@(posedge clk) disable iff (!rst_n)
      starve_cnt <= 3'(STARVE));

endmodule

// File: tb/tb_jtcontra_gfx_romarb.sv
// Bench for the graphics ROM arbiter: directed vector table, starvation and
// reset sequences, then randomized requesters against a behavioural SDRAM.
module tb_jtcontra_gfx_romarb;

   localparam int AW = 18;
   localparam int DW = 16;
   localparam int NV = 23;

   logic          clk;
   logic          rst_n;
   logic          tile_cs;
   logic [AW-1:0] tile_addr;
   logic          tile_ok;
   logic [DW-1:0] tile_data;
   logic          obj_cs;
   logic [AW-1:0] obj_addr;
   logic          obj_ok;
   logic [DW-1:0] obj_data;
   logic          rom_cs;
   logic [AW-1:0] rom_addr;
   logic          rom_ok;
   logic [DW-1:0] rom_data;
   logic [2:0]    starve_cnt;

   logic          man_ok;
   logic [DW-1:0] man_data;
   logic          sd_auto;
   logic          sd_rand;
   logic          sd_ok;
   logic [DW-1:0] sd_data;
   int            sd_age;
   int            sd_lat;
   logic [AW-1:0] sd_last;
   logic          sd_last_cs;

   int n_tests = 0;
   int n_fail  = 0;

   assign rom_ok   = sd_auto ? sd_ok : man_ok;
   assign rom_data = sd_auto ? sd_data : man_data;

   jtcontra_gfx_romarb dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .tile_cs    (tile_cs),
      .tile_addr  (tile_addr),
      .tile_ok    (tile_ok),
      .tile_data  (tile_data),
      .obj_cs     (obj_cs),
      .obj_addr   (obj_addr),
      .obj_ok     (obj_ok),
      .obj_data   (obj_data),
      .rom_cs     (rom_cs),
      .rom_addr   (rom_addr),
      .rom_ok     (rom_ok),
      .rom_data   (rom_data),
      .starve_cnt (starve_cnt)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [DW-1:0] sd_word(input logic [AW-1:0] a);
      return a[15:0] ^ 16'h5AC3 ^ {14'd0, a[17:16]};
   endfunction

   // SDRAM model: ok after sd_lat cycles of a stable request, data is a fixed function of address
   initial begin
      sd_ok = 1'b0; sd_data = '0; sd_age = 0; sd_lat = 3; sd_last = '0; sd_last_cs = 1'b0;
   end
   always @(posedge clk) begin
      #1;
      if (rom_cs && sd_last_cs && rom_addr == sd_last) begin
         sd_age = sd_age + 1;
      end else begin
         sd_age = 1;
         if (sd_rand) sd_lat = $urandom_range(2, 4);
      end
      sd_last    = rom_addr;
      sd_last_cs = rom_cs;
      sd_ok      = rom_cs && (sd_age >= sd_lat);
      sd_data    = sd_word(rom_addr);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic check_port(input string nm, input logic pcs, input logic [AW-1:0] paddr,
                             input logic ok, input logic [DW-1:0] data,
                             inout logic have, inout logic [AW-1:0] last);
      if (!pcs) chk({nm, "_ok_without_cs"}, ok, 1'b0);
      else if (have && paddr == last) chk({nm, "_hit_ok"}, ok, 1'b1);
      if (ok) begin
         chk({nm, "_data"}, data, sd_word(paddr));
         have = 1'b1;
         last = paddr;
      end
   endtask

   typedef struct {
      logic          t_cs;
      logic [AW-1:0] t_addr;
      logic          o_cs;
      logic [AW-1:0] o_addr;
      logic          r_ok;
      logic [DW-1:0] r_data;
      logic          e_rom_cs;
      logic [AW-1:0] e_rom_addr;
      logic          e_t_ok;
      logic [DW-1:0] e_t_data;
      logic          e_o_ok;
      logic [DW-1:0] e_o_data;
      logic [2:0]    e_starve;
   } vec_t;

   vec_t vecs[NV];

   initial begin
      string         order;
      int            exp_s;
      int            ncomp;
      logic          p_tcs, p_ocs;
      logic [AW-1:0] p_taddr, p_oaddr;
      logic          t_have, o_have;
      logic [AW-1:0] t_last, o_last;
      int            t_wait, o_wait, t_max, o_max;

      // tile miss/hit, mid-wait reissue with stale ok, obj abort, obj refetch
      vecs[0]  = '{1, 18'h01234, 0, 18'h0,     0, 16'h0,    1, 18'h01234, 0, 16'h0,    0, 16'h0,    3'd0};
      vecs[1]  = '{1, 18'h01234, 0, 18'h0,     0, 16'h0,    1, 18'h01234, 0, 16'h0,    0, 16'h0,    3'd0};
      vecs[2]  = '{1, 18'h01234, 0, 18'h0,     0, 16'h0,    1, 18'h01234, 0, 16'h0,    0, 16'h0,    3'd0};
      vecs[3]  = '{1, 18'h01234, 0, 18'h0,     0, 16'h0,    1, 18'h01234, 0, 16'h0,    0, 16'h0,    3'd0};
      vecs[4]  = '{1, 18'h01234, 0, 18'h0,     1, 16'hA5A5, 0, 18'h01234, 1, 16'hA5A5, 0, 16'h0,    3'd0};
      vecs[5]  = '{1, 18'h01234, 0, 18'h0,     0, 16'h0,    0, 18'h01234, 1, 16'hA5A5, 0, 16'h0,    3'd0};
      vecs[6]  = '{0, 18'h01234, 0, 18'h0,     0, 16'h0,    0, 18'h01234, 0, 16'hA5A5, 0, 16'h0,    3'd0};
      vecs[7]  = '{1, 18'h01234, 0, 18'h0,     0, 16'h0,    0, 18'h01234, 1, 16'hA5A5, 0, 16'h0,    3'd0};
      vecs[8]  = '{1, 18'h00100, 0, 18'h0,     0, 16'h0,    1, 18'h00100, 0, 16'hA5A5, 0, 16'h0,    3'd0};
      vecs[9]  = '{1, 18'h00100, 0, 18'h0,     0, 16'h0,    1, 18'h00100, 0, 16'hA5A5, 0, 16'h0,    3'd0};
      vecs[10] = '{1, 18'h00101, 0, 18'h0,     0, 16'h0,    1, 18'h00101, 0, 16'hA5A5, 0, 16'h0,    3'd0};
      vecs[11] = '{1, 18'h00101, 0, 18'h0,     1, 16'hDEAD, 1, 18'h00101, 0, 16'hA5A5, 0, 16'h0,    3'd0};
      vecs[12] = '{1, 18'h00101, 0, 18'h0,     0, 16'h0,    1, 18'h00101, 0, 16'hA5A5, 0, 16'h0,    3'd0};
      vecs[13] = '{1, 18'h00101, 0, 18'h0,     1, 16'hBEEF, 0, 18'h00101, 1, 16'hBEEF, 0, 16'h0,    3'd0};
      vecs[14] = '{1, 18'h00101, 0, 18'h0,     0, 16'h0,    0, 18'h00101, 1, 16'hBEEF, 0, 16'h0,    3'd0};
      vecs[15] = '{0, 18'h00101, 1, 18'h02000, 0, 16'h0,    1, 18'h02000, 0, 16'hBEEF, 0, 16'h0,    3'd0};
      vecs[16] = '{0, 18'h00101, 1, 18'h02000, 0, 16'h0,    1, 18'h02000, 0, 16'hBEEF, 0, 16'h0,    3'd0};
      vecs[17] = '{0, 18'h00101, 0, 18'h02000, 1, 16'h1111, 0, 18'h02000, 0, 16'hBEEF, 0, 16'h0,    3'd0};
      vecs[18] = '{0, 18'h00101, 0, 18'h02000, 0, 16'h0,    0, 18'h02000, 0, 16'hBEEF, 0, 16'h0,    3'd0};
      vecs[19] = '{0, 18'h00101, 1, 18'h02000, 0, 16'h0,    1, 18'h02000, 0, 16'hBEEF, 0, 16'h0,    3'd0};
      vecs[20] = '{0, 18'h00101, 1, 18'h02000, 0, 16'h0,    1, 18'h02000, 0, 16'hBEEF, 0, 16'h0,    3'd0};
      vecs[21] = '{0, 18'h00101, 1, 18'h02000, 1, 16'h2222, 0, 18'h02000, 0, 16'hBEEF, 1, 16'h2222, 3'd0};
      vecs[22] = '{0, 18'h00101, 1, 18'h02000, 0, 16'h0,    0, 18'h02000, 0, 16'hBEEF, 1, 16'h2222, 3'd0};

      rst_n = 1'b0; tile_cs = 1'b0; tile_addr = '0; obj_cs = 1'b0; obj_addr = '0;
      man_ok = 1'b0; man_data = '0; sd_auto = 1'b0; sd_rand = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_rom_cs", rom_cs, 1'b0);
      chk("rst_rom_addr", rom_addr, '0);
      chk("rst_tile_ok", tile_ok, 1'b0);
      chk("rst_obj_ok", obj_ok, 1'b0);
      chk("rst_tile_data", tile_data, '0);
      chk("rst_obj_data", obj_data, '0);
      chk("rst_starve", starve_cnt, 3'd0);
      #2 rst_n = 1'b1;

      for (int i = 0; i < NV; i++) begin
         tile_cs = vecs[i].t_cs; tile_addr = vecs[i].t_addr;
         obj_cs  = vecs[i].o_cs; obj_addr  = vecs[i].o_addr;
         man_ok  = vecs[i].r_ok; man_data  = vecs[i].r_data;
         step();
         chk($sformatf("v%0d_rom_cs", i),    rom_cs,     vecs[i].e_rom_cs);
         chk($sformatf("v%0d_rom_addr", i),  rom_addr,   vecs[i].e_rom_addr);
         chk($sformatf("v%0d_tile_ok", i),   tile_ok,    vecs[i].e_t_ok);
         chk($sformatf("v%0d_tile_data", i), tile_data,  vecs[i].e_t_data);
         chk($sformatf("v%0d_obj_ok", i),    obj_ok,     vecs[i].e_o_ok);
         chk($sformatf("v%0d_obj_data", i),  obj_data,   vecs[i].e_o_data);
         chk($sformatf("v%0d_starve", i),    starve_cnt, vecs[i].e_starve);
      end

      // both requesters miss continuously: four tile grants, then one object grant
      man_ok = 1'b0;
      tile_cs = 1'b1; tile_addr = 18'h10000;
      obj_cs  = 1'b1; obj_addr  = 18'h20000;
      sd_lat = 3; sd_auto = 1'b1;
      order = ""; exp_s = 0; ncomp = 0;
      for (int c = 0; c < 400 && ncomp < 12; c++) begin
         step();
         if (tile_ok) begin
            order = {order, "T"};
            exp_s = (exp_s < 4) ? exp_s + 1 : 4;
            chk("starve_after_tile", starve_cnt, exp_s);
            tile_addr = tile_addr + 18'd1;
            ncomp++;
         end
         if (obj_ok) begin
            order = {order, "O"};
            exp_s = 0;
            chk("starve_after_obj", starve_cnt, exp_s);
            obj_addr = obj_addr + 18'd1;
            ncomp++;
         end
      end
      chk("starve_completions", ncomp, 12);
      n_tests++;
      if (order != "TTTTOTTTTOTT") begin
         n_fail++;
         $display("FAIL grant_order: got %s expected TTTTOTTTTOTT", order);
      end

      // async reset while a tile fetch is outstanding
      sd_auto = 1'b0; man_ok = 1'b0;
      step();
      chk("pre_rst_rom_cs", rom_cs, 1'b1);
      chk("pre_rst_starve", starve_cnt, 3'd2);
      #3 rst_n = 1'b0;
      #1;
      chk("async_rst_rom_cs", rom_cs, 1'b0);
      chk("async_rst_tile_ok", tile_ok, 1'b0);
      chk("async_rst_obj_ok", obj_ok, 1'b0);
      chk("async_rst_starve", starve_cnt, 3'd0);
      tile_cs = 1'b0; obj_cs = 1'b0;
      man_ok = 1'b1; man_data = 16'h7777;
      #2 rst_n = 1'b1;
      step();
      step();
      chk("late_ok_rom_cs", rom_cs, 1'b0);
      chk("late_ok_tile_ok", tile_ok, 1'b0);
      chk("late_ok_obj_ok", obj_ok, 1'b0);
      chk("late_ok_tile_data", tile_data, '0);
      man_ok = 1'b0;
      tile_cs = 1'b1; tile_addr = 18'h01234;
      step();
      chk("post_rst_miss_rom_cs", rom_cs, 1'b1);
      chk("post_rst_miss_tile_ok", tile_ok, 1'b0);

      // randomized requesters against the SDRAM model
      rst_n = 1'b0; tile_cs = 1'b0; obj_cs = 1'b0;
      step();
      rst_n = 1'b1;
      sd_rand = 1'b1; sd_auto = 1'b1;
      p_tcs = 1'b0; p_ocs = 1'b0; p_taddr = '0; p_oaddr = '0;
      t_have = 1'b0; o_have = 1'b0; t_last = '0; o_last = '0;
      t_wait = 0; o_wait = 0; t_max = 0; o_max = 0;
      for (int c = 0; c < 3000; c++) begin
         step();
         check_port("tile", p_tcs, p_taddr, tile_ok, tile_data, t_have, t_last);
         check_port("obj", p_ocs, p_oaddr, obj_ok, obj_data, o_have, o_last);
         chk("starve_bound", starve_cnt <= 3'd4, 1'b1);
         if (!p_ocs) chk("starve_clear_no_obj", starve_cnt, 3'd0);

         if (tile_cs && tile_ok) begin
            t_wait = 0;
            if ($urandom_range(0, 9) < 3) tile_cs = 1'b0;
            else tile_addr = 18'($urandom_range(0, 5));
         end else if (tile_cs) begin
            t_wait++;
            case ($urandom_range(0, 99))
               0, 1, 2: begin tile_cs = 1'b0; t_wait = 0; end
               3, 4, 5: begin tile_addr = 18'($urandom_range(0, 5)); t_wait = 0; end
               default: ;
            endcase
         end else if ($urandom_range(0, 1) == 1) begin
            tile_cs = 1'b1; tile_addr = 18'($urandom_range(0, 5));
         end

         if (obj_cs && obj_ok) begin
            o_wait = 0;
            if ($urandom_range(0, 9) < 3) obj_cs = 1'b0;
            else obj_addr = 18'h30000 | 18'($urandom_range(0, 5));
         end else if (obj_cs) begin
            o_wait++;
            case ($urandom_range(0, 99))
               0, 1, 2: begin obj_cs = 1'b0; o_wait = 0; end
               3, 4, 5: begin obj_addr = 18'h30000 | 18'($urandom_range(0, 5)); o_wait = 0; end
               default: ;
            endcase
         end else if ($urandom_range(0, 1) == 1) begin
            obj_cs = 1'b1; obj_addr = 18'h30000 | 18'($urandom_range(0, 5));
         end

         if (t_wait > t_max) t_max = t_wait;
         if (o_wait > o_max) o_max = o_wait;
         p_tcs = tile_cs; p_taddr = tile_addr;
         p_ocs = obj_cs;  p_oaddr = obj_addr;
      end
      chk("tile_wait_bounded", t_max <= 150, 1'b1);
      chk("obj_wait_bounded", o_max <= 150, 1'b1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
